// File: rtl/clock_meter_defs.sv
// Shared definitions for the clock period meter.
//   meter_state_e   : FSM state encodings (idle / measuring / timed out)
//   DefaultCntWidth : default width of the cycle counter and measurement outputs
package clock_meter_defs;

  localparam int unsigned DefaultCntWidth = 16;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StMeasure = 2'b01,
    StTimeout = 2'b10
  } meter_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser followed by a history flop; flags single-cycle rise/fall
// events of an asynchronous input in the clk domain.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   din     : asynchronous input
//   rise    : one-cycle pulse, synchronised din went 0 -> 1
//   fall    : one-cycle pulse, synchronised din went 1 -> 0
module sync_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow free-running square wave in clk cycles.
//   clk       : system clock
//   reset_n   : asynchronous active-low reset
//   slow_in   : measured signal, asynchronous to clk
//   period    : clk cycles between the last two rising edges
//   high_time : clk cycles from rise to fall within that period
//   valid     : one-cycle pulse when period/high_time update
//   locked    : last two measurements identical
//   timeout   : no rising edge for TIMEOUT_CYC cycles
module clock_period_meter
  import clock_meter_defs::*;
#(
  parameter int unsigned CNT_WIDTH   = DefaultCntWidth,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 slow_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 valid,
  output logic                 locked,
  output logic                 timeout
);

  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(TIMEOUT_CYC - 1);

  logic rise, fall;

  sync_edge_detect u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (slow_in),
    .rise    (rise),
    .fall    (fall)
  );

  meter_state_e         state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] hi_cap_q, hi_cap_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] high_q, high_d;
  logic                 valid_q, valid_d;
  logic                 locked_q, locked_d;
  logic                 timeout_q, timeout_d;
  // A previous measurement exists to compare against for lock.
  logic                 have_prev_q, have_prev_d;

  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 cnt_at_max;

  // cnt never exceeds CntMax <= 2^CNT_WIDTH-2, so cnt+1 cannot wrap.
  assign cnt_inc    = cnt_q + CNT_WIDTH'(1);
  assign cnt_at_max = (cnt_q == CntMax);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_cap_d    = hi_cap_q;
    period_d    = period_q;
    high_d      = high_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    timeout_d   = timeout_q;
    have_prev_d = have_prev_q;

    if (rise) begin
      cnt_d = '0;
    end else if (!cnt_at_max) begin
      cnt_d = cnt_inc;
    end

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StMeasure;
        end else if (cnt_at_max) begin
          state_d     = StTimeout;
          timeout_d   = 1'b1;
          locked_d    = 1'b0;
          have_prev_d = 1'b0;
        end
      end
      StMeasure: begin
        if (fall) begin
          hi_cap_d = cnt_inc;
        end
        // Rise wins over a simultaneous counter saturation.
        if (rise) begin
          period_d    = cnt_inc;
          high_d      = hi_cap_q;
          valid_d     = 1'b1;
          locked_d    = have_prev_q && (cnt_inc == period_q) && (hi_cap_q == high_q);
          have_prev_d = 1'b1;
        end else if (cnt_at_max) begin
          state_d     = StTimeout;
          timeout_d   = 1'b1;
          locked_d    = 1'b0;
          have_prev_d = 1'b0;
        end
      end
      StTimeout: begin
        // The period ending at this rise is partial and is dropped.
        if (rise) begin
          state_d   = StMeasure;
          timeout_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hi_cap_q    <= '0;
      period_q    <= '0;
      high_q      <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      have_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_cap_q    <= hi_cap_d;
      period_q    <= period_d;
      high_q      <= high_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_clock_period_meter.sv
module tb_clock_period_meter;

  localparam int unsigned CW = 16;
  localparam int unsigned TO = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          slow_in;
  logic          slow_drv;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          valid;
  logic          locked;
  logic          timeout;

  int n_pass  = 0;
  int n_total = 0;

  // Divide-by-5 reference divider on the same clk: period 5, high 2.
  logic       div_en;
  logic [2:0] div_cnt;
  logic       div_out;

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)    div_cnt <= 3'd0;
    else if (div_en) div_cnt <= (div_cnt == 3'd4) ? 3'd0 : div_cnt + 3'd1;
  end
  assign div_out = div_en && (div_cnt < 3'd2);
  assign slow_in = div_en ? div_out : slow_drv;

  clock_period_meter #(
    .CNT_WIDTH   (CW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .slow_in   (slow_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .locked    (locked),
    .timeout   (timeout)
  );

  // Record every valid pulse, sampled away from the active edge.
  logic [CW-1:0] q_period[$];
  logic [CW-1:0] q_high[$];
  logic          q_locked[$];
  logic          to_seen;

  always @(negedge clk) begin
    if (valid) begin
      q_period.push_back(period);
      q_high.push_back(high_time);
      q_locked.push_back(locked);
    end
    if (timeout) to_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    q_period.delete();
    q_high.delete();
    q_locked.delete();
  endtask

  // Synchronous square wave: n periods of p cycles, high for the first h.
  task automatic gen_periods(input int p, input int h, input int n);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < p; c++) begin
        slow_drv = (c < h);
        tick(1);
      end
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    slow_drv = 1'b0;
    div_en   = 1'b0;
    to_seen  = 1'b0;
    #3;
    n_total++;
    if (valid !== 1'b0 || locked !== 1'b0 || timeout !== 1'b0)
      $display("FAIL reset_flags got v=%0b l=%0b t=%0b want 0/0/0", valid, locked, timeout);
    else n_pass++;
    n_total++;
    if (period !== 16'd0 || high_time !== 16'd0)
      $display("FAIL reset_meas got %0d/%0d want 0/0", period, high_time);
    else n_pass++;
    tick(2);
    reset_n = 1'b1;
    clear_log();
    tick(TO - 1);
    n_total++;
    if (timeout !== 1'b0) $display("FAIL timeout_early got %0b want 0", timeout);
    else n_pass++;
    tick(1);
    n_total++;
    if (timeout !== 1'b1) $display("FAIL timeout_at_64 got %0b want 1", timeout);
    else n_pass++;
    n_total++;
    if (q_period.size() != 0 || period !== 16'd0)
      $display("FAIL idle_no_valid got n=%0d period=%0d want 0/0", q_period.size(), period);
    else n_pass++;
  endtask

  task automatic test_period_10_4();
    logic exp_lk[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    clear_log();
    gen_periods(10, 4, 5);
    n_total++;
    if (q_period.size() != 4) $display("FAIL p10_count got %0d want 4", q_period.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < q_period.size(); i++) begin
      n_total++;
      if (q_period[i] !== 16'd10 || q_high[i] !== 16'd4 || q_locked[i] !== exp_lk[i])
        $display("FAIL p10_valid%0d got %0d/%0d lk=%0b want 10/4 lk=%0b",
                 i, q_period[i], q_high[i], q_locked[i], exp_lk[i]);
      else n_pass++;
    end
    n_total++;
    if (timeout !== 1'b0) $display("FAIL p10_timeout_clear got %0b want 0", timeout);
    else n_pass++;
  endtask

  task automatic test_period_change();
    logic [CW-1:0] exp_p[4]  = '{16'd10, 16'd12, 16'd12, 16'd12};
    logic [CW-1:0] exp_h[4]  = '{16'd4, 16'd6, 16'd6, 16'd6};
    logic          exp_lk[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    clear_log();
    gen_periods(12, 6, 4);
    n_total++;
    if (q_period.size() != 4) $display("FAIL p12_count got %0d want 4", q_period.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < q_period.size(); i++) begin
      n_total++;
      if (q_period[i] !== exp_p[i] || q_high[i] !== exp_h[i] || q_locked[i] !== exp_lk[i])
        $display("FAIL p12_valid%0d got %0d/%0d lk=%0b want %0d/%0d lk=%0b", i, q_period[i],
                 q_high[i], q_locked[i], exp_p[i], exp_h[i], exp_lk[i]);
      else n_pass++;
    end
  endtask

  task automatic test_timeout_resume();
    // Last rise was driven 12 edges ago; its cnt clear lands 3 edges after the drive.
    tick(54);
    n_total++;
    if (timeout !== 1'b0 || locked !== 1'b1)
      $display("FAIL to_before got t=%0b l=%0b want 0/1", timeout, locked);
    else n_pass++;
    tick(1);
    n_total++;
    if (timeout !== 1'b1 || locked !== 1'b0)
      $display("FAIL to_assert got t=%0b l=%0b want 1/0", timeout, locked);
    else n_pass++;
    n_total++;
    if (period !== 16'd12 || high_time !== 16'd6)
      $display("FAIL to_hold got %0d/%0d want 12/6", period, high_time);
    else n_pass++;
    clear_log();
    gen_periods(10, 4, 3);
    n_total++;
    if (q_period.size() != 2) $display("FAIL resume_count got %0d want 2", q_period.size());
    else n_pass++;
    if (q_period.size() == 2) begin
      n_total++;
      if (q_period[0] !== 16'd10 || q_high[0] !== 16'd4 || q_locked[0] !== 1'b0 ||
          q_locked[1] !== 1'b1)
        $display("FAIL resume_meas got %0d/%0d lk=%0b,%0b want 10/4 lk=0,1",
                 q_period[0], q_high[0], q_locked[0], q_locked[1]);
      else n_pass++;
    end
    n_total++;
    if (timeout !== 1'b0) $display("FAIL resume_timeout got %0b want 0", timeout);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    slow_drv = 1'b1;
    tick(4);
    #2;
    reset_n = 1'b0;
    #1;
    n_total++;
    if (valid !== 1'b0 || locked !== 1'b0 || timeout !== 1'b0 || period !== 16'd0 ||
        high_time !== 16'd0)
      $display("FAIL async_reset got v=%0b l=%0b t=%0b p=%0d h=%0d want all 0",
               valid, locked, timeout, period, high_time);
    else n_pass++;
    slow_drv = 1'b0;
    tick(3);
    reset_n = 1'b1;
    clear_log();
    gen_periods(8, 3, 3);
    n_total++;
    if (q_period.size() != 2) $display("FAIL rst_resume_count got %0d want 2", q_period.size());
    else n_pass++;
    if (q_period.size() == 2) begin
      n_total++;
      if (q_period[0] !== 16'd8 || q_high[0] !== 16'd3 || q_locked[0] !== 1'b0 ||
          q_locked[1] !== 1'b1)
        $display("FAIL rst_resume_meas got %0d/%0d lk=%0b,%0b want 8/3 lk=0,1",
                 q_period[0], q_high[0], q_locked[0], q_locked[1]);
      else n_pass++;
    end
  endtask

  // Period 64: cnt reaches TIMEOUT_CYC-1 in the rise cycle; the rise must win.
  task automatic test_rise_priority();
    logic [CW-1:0] exp_p[3]  = '{16'd8, 16'd64, 16'd64};
    logic [CW-1:0] exp_h[3]  = '{16'd3, 16'd10, 16'd10};
    logic          exp_lk[3] = '{1'b1, 1'b0, 1'b1};
    clear_log();
    to_seen = 1'b0;
    gen_periods(64, 10, 3);
    n_total++;
    if (to_seen !== 1'b0) $display("FAIL prio_no_timeout got %0b want 0", to_seen);
    else n_pass++;
    n_total++;
    if (q_period.size() != 3) $display("FAIL prio_count got %0d want 3", q_period.size());
    else n_pass++;
    for (int i = 0; i < 3 && i < q_period.size(); i++) begin
      n_total++;
      if (q_period[i] !== exp_p[i] || q_high[i] !== exp_h[i] || q_locked[i] !== exp_lk[i])
        $display("FAIL prio_valid%0d got %0d/%0d lk=%0b want %0d/%0d lk=%0b", i, q_period[i],
                 q_high[i], q_locked[i], exp_p[i], exp_h[i], exp_lk[i]);
      else n_pass++;
    end
  endtask

  task automatic test_divider();
    int bad_meas = 0;
    int lock_drops = 0;
    div_en = 1'b1;
    tick(30);
    n_total++;
    if (locked !== 1'b1) $display("FAIL div_locked got %0b want 1", locked);
    else n_pass++;
    clear_log();
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (locked !== 1'b1) lock_drops++;
    end
    n_total++;
    if (lock_drops != 0) $display("FAIL div_lock_hold got %0d drops want 0", lock_drops);
    else n_pass++;
    n_total++;
    if (q_period.size() != 20) $display("FAIL div_count got %0d want 20", q_period.size());
    else n_pass++;
    for (int i = 0; i < q_period.size(); i++)
      if (q_period[i] !== 16'd5 || q_high[i] !== 16'd2) bad_meas++;
    n_total++;
    if (bad_meas != 0) $display("FAIL div_meas got %0d bad want 0 (5/2)", bad_meas);
    else n_pass++;
    div_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_period_10_4();
    test_period_change();
    test_timeout_resume();
    test_reset_mid();
    test_rise_priority();
    test_divider();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
